// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter controller with one branch delay slot and a
//               halt-on-transfer-to-HALT_ADDR rule.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] instr_address,
   output logic [31:0] link_addr,
   output logic        delay_slot,
   output logic        active,
   output logic        addr_err
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DELAY  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_tgt;
   logic [31:0] w_tgt_nxt;
   logic        r_delay_slot;
   logic        w_delay_slot_nxt;
   logic        r_active;
   logic        w_active_nxt;
   logic        r_addr_err;
   logic        w_addr_err_nxt;
   logic        w_adv;
   logic [31:0] w_sel_target;

   assign w_adv        = clk_enable & ~stall;
   assign w_sel_target = jump ? jump_target : branch_target;

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_tgt_nxt        = r_tgt;
      w_delay_slot_nxt = r_delay_slot;
      w_active_nxt     = r_active;
      w_addr_err_nxt   = r_addr_err;
      case (r_state)
         S_RUN: begin
            if (w_adv) begin
               w_pc_nxt = r_pc + 32'd4;
               if (jump | branch_taken) begin
                  w_tgt_nxt        = w_sel_target & c_align_mask;
                  w_delay_slot_nxt = 1'b1;
                  w_state_nxt      = S_DELAY;
                  if (w_sel_target[1:0] != 2'b00) begin
                     w_addr_err_nxt = 1'b1;
                  end
               end
            end
         end
         S_DELAY: begin
            // Transfer inputs are deliberately ignored while fetching the delay slot.
            if (w_adv) begin
               w_pc_nxt         = r_tgt;
               w_delay_slot_nxt = 1'b0;
               if (r_tgt == HALT_ADDR) begin
                  w_active_nxt = 1'b0;
                  w_state_nxt  = S_HALTED;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_HALTED: begin
            w_pc_nxt         = HALT_ADDR;
            w_active_nxt     = 1'b0;
            w_delay_slot_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_pc         <= RESET_VECTOR;
         r_tgt        <= 32'd0;
         r_delay_slot <= 1'b0;
         r_active     <= 1'b1;
         r_addr_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_tgt        <= w_tgt_nxt;
         r_delay_slot <= w_delay_slot_nxt;
         r_active     <= w_active_nxt;
         r_addr_err   <= w_addr_err_nxt;
      end
   end

   assign instr_address = r_pc;
   assign link_addr     = r_pc + 32'd8;
   assign delay_slot    = r_delay_slot;
   assign active        = r_active;
   assign addr_err      = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed vector table plus randomized run against a
//               fetch-queue reference model for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   localparam logic [31:0] c_rv   = 32'hBFC00000;
   localparam logic [31:0] c_halt = 32'h00000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_enable;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] instr_address;
   logic [31:0] link_addr;
   logic        delay_slot;
   logic        active;
   logic        addr_err;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VECTOR(c_rv), .HALT_ADDR(c_halt)) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_enable    (clk_enable),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .instr_address (instr_address),
      .link_addr     (link_addr),
      .delay_slot    (delay_slot),
      .active        (active),
      .addr_err      (addr_err)
   );

   typedef struct {
      logic        rst;
      logic        ce;
      logic        st;
      logic        br;
      logic [31:0] bt;
      logic        j;
      logic [31:0] jt;
      logic [31:0] e_pc;
      logic        e_ds;
      logic        e_act;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Reference model: a taken transfer queues the two forced fetches (slot, target).
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic        m_halted;
   logic        m_err;
   logic        m_ds;

   function automatic vec_t mk(logic rst, logic ce, logic st, logic br, logic [31:0] bt,
                               logic j, logic [31:0] jt, logic [31:0] e_pc, logic e_ds,
                               logic e_act, logic e_err);
      vec_t v;
      v.rst = rst; v.ce = ce; v.st = st; v.br = br; v.bt = bt; v.j = j; v.jt = jt;
      v.e_pc = e_pc; v.e_ds = e_ds; v.e_act = e_act; v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic apply(input logic rst, input logic ce, input logic st, input logic br,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
      reset = rst; clk_enable = ce; stall = st;
      branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(input logic rst, input logic ce, input logic st, input logic br,
                             input logic [31:0] bt, input logic j, input logic [31:0] jt);
      logic [31:0] sel;
      logic        last;
      if (rst) begin
         m_pc = c_rv; m_q.delete(); m_halted = 1'b0; m_err = 1'b0; m_ds = 1'b0;
      end else if (ce && !st && !m_halted) begin
         if (m_q.size() == 0 && (j || br)) begin
            sel = j ? jt : bt;
            if (sel[1:0] != 2'b00) m_err = 1'b1;
            m_q.push_back(m_pc + 32'd4);
            m_q.push_back({sel[31:2], 2'b00});
         end
         if (m_q.size() > 0) begin
            last = (m_q.size() == 1);
            m_pc = m_q.pop_front();
            m_ds = !last;
            if (last && m_pc == c_halt) m_halted = 1'b1;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   initial begin
      reset = 1'b1; clk_enable = 1'b1; stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;

      //           rst ce st br bt            j  jt            pc            ds act err
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00004, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00008, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC0000C, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'hBFC0000C, 0, 0,            32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'h00000000, 0, 0,            32'hBFC0000C, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00010, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            1, 32'h00000000, 32'hBFC00014, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'h00000000, 0, 0, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 1, 0, 1, 32'hBFC00000, 1, 32'hBFC00003, 32'h00000000, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'hBFC00020, 0, 0,            32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,            32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,            32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00020, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00024, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'hBFC00040, 0, 0,            32'hBFC00028, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            32'hBFC00028, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            32'hBFC00028, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00040, 0, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            1, 32'hBFC00100, 32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00004, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00008, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            1, 32'hBFC00013, 32'hBFC0000C, 1, 1, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00010, 0, 1, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00014, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));
      // Sequential wrap through zero keeps running.
      vecs.push_back(mk(0, 1, 0, 0, 0,            1, 32'hFFFFFFF8, 32'hBFC00004, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hFFFFFFF8, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hFFFFFFFC, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'h00000000, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'h00000004, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'hBFC00300, 1, 32'hBFC00200, 32'h00000008, 1, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00200, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0,            1, 32'h00000000, 32'hBFC00200, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,            0, 0,            32'hBFC00204, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'hBFC00000, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].ce, vecs[i].st, vecs[i].br, vecs[i].bt, vecs[i].j, vecs[i].jt);
         check($sformatf("vec%0d pc", i), instr_address, vecs[i].e_pc);
         check($sformatf("vec%0d link", i), link_addr, vecs[i].e_pc + 32'd8);
         check($sformatf("vec%0d delay_slot", i), {31'd0, delay_slot}, {31'd0, vecs[i].e_ds});
         check($sformatf("vec%0d active", i), {31'd0, active}, {31'd0, vecs[i].e_act});
         check($sformatf("vec%0d addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].e_err});
      end

      model_step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
      for (int k = 0; k < 3000; k++) begin
         logic        r_rst, r_ce, r_st, r_br, r_j;
         logic [31:0] r_bt, r_jt;
         r_rst = ($urandom_range(0, 99) == 0);
         r_ce  = ($urandom_range(0, 9) != 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_br  = ($urandom_range(0, 5) == 0);
         r_j   = ($urandom_range(0, 7) == 0);
         r_bt  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
         r_jt  = ($urandom_range(0, 9) == 0) ? 32'h2 : $urandom();
         if ($urandom_range(0, 1) == 0) r_bt[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 0) r_jt[1:0] = 2'b00;
         apply(r_rst, r_ce, r_st, r_br, r_bt, r_j, r_jt);
         model_step(r_rst, r_ce, r_st, r_br, r_bt, r_j, r_jt);
         check($sformatf("rnd%0d pc", k), instr_address, m_pc);
         check($sformatf("rnd%0d link", k), link_addr, m_pc + 32'd8);
         check($sformatf("rnd%0d delay_slot", k), {31'd0, delay_slot}, {31'd0, m_ds});
         check($sformatf("rnd%0d active", k), {31'd0, active}, {31'd0, !m_halted});
         check($sformatf("rnd%0d addr_err", k), {31'd0, addr_err}, {31'd0, m_err});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
